// File: rtl/vc_input_port_if.sv
// Handshake bundle for the virtual-channel input port: write side, allocation side and output flit.
interface vc_input_port_if #(
  parameter int VC_ID_W    = 1,
  parameter int VC_DEPTH_W = 2,
  parameter int DATA_W     = 10
);
  localparam int VC_NUM = 2**VC_ID_W;

  logic [DATA_W-1:0]        data_i;
  logic                     wr_en_i;
  logic [VC_ID_W-1:0]       wr_vc_i;
  logic [VC_NUM-1:0]        rdy_o;
  logic [VC_NUM-1:0]        req_o;
  logic [VC_NUM*DATA_W-1:0] header_o;
  logic [VC_NUM-1:0]        chan_alloc_i;
  logic [VC_NUM-1:0]        chan_rdy_i;
  logic [DATA_W-1:0]        data_o;
  logic                     data_vld_o;
  logic [VC_ID_W-1:0]       data_vc_o;

  modport slave (
    input  data_i, wr_en_i, wr_vc_i, chan_alloc_i, chan_rdy_i,
    output rdy_o, req_o, header_o, data_o, data_vld_o, data_vc_o
  );
  modport master (
    output data_i, wr_en_i, wr_vc_i, chan_alloc_i, chan_rdy_i,
    input  rdy_o, req_o, header_o, data_o, data_vld_o, data_vc_o
  );
endinterface

// File: rtl/vc_input_port.sv
// Router input port: per-VC circular FIFO + IDLE/WAIT_ALLOC/ACTIVE FSM, round-robin output select.
// Define VC_CREDIT_EN to treat chan_rdy_i as credit-return pulses instead of a level ready.
module vc_lane #(
  parameter int VC_DEPTH_W = 2,
  parameter int DATA_W     = 10
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              grant,
  input  logic              send,
  input  logic              ds_rdy,
  output logic              full,
  output logic [DATA_W-1:0] front,
  output logic              req,
  output logic              elig
);
  localparam int DEPTH = 2**VC_DEPTH_W;
  localparam logic [VC_DEPTH_W:0] DEPTH_C = (VC_DEPTH_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_ALLOC, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [VC_DEPTH_W-1:0]        rd_ptr, wr_ptr;
  logic [VC_DEPTH_W:0]          cnt;
  logic                         empty, wr_ok, discard, pop, ds_ok;

  assign full    = cnt == DEPTH_C;
  assign empty   = cnt == '0;
  assign front   = mem[rd_ptr];
  // A full VC drops the write even if it pops this cycle.
  assign wr_ok   = push & ~full;
  assign discard = (state == IDLE) & ~empty & ~front[DATA_W-1];
  assign pop     = discard | send;

  always_ff @(posedge gclk)
    if (wr_ok) mem[wr_ptr] <= din;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) state <= IDLE;
    else         state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (!empty && front[DATA_W-1]) state_nxt = WAIT_ALLOC;
      WAIT_ALLOC: if (grant) state_nxt = ACTIVE;
      ACTIVE:     if (send && front[DATA_W-2]) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

`ifdef VC_CREDIT_EN
  logic [VC_DEPTH_W:0] credit;
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                                credit <= DEPTH_C;
    else if (send && !ds_rdy)                   credit <= credit - 1'b1;
    else if (ds_rdy && !send && credit != DEPTH_C) credit <= credit + 1'b1;
  end
  assign ds_ok = credit != '0;
`else
  assign ds_ok = ds_rdy;
`endif

  assign req  = state == WAIT_ALLOC;
  assign elig = (state == ACTIVE) & ~empty & ds_ok;
endmodule

module vc_input_port #(
  parameter int VC_ID_W    = 1,
  parameter int VC_DEPTH_W = 2,
  parameter int DATA_W     = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  vc_input_port_if.slave   bus
);
  localparam int VC_NUM = 2**VC_ID_W;
  localparam int STAGES = 1;

  logic [1:0]                    rst_sync;
  logic                          rst_n;
  logic [VC_NUM-1:0]             wr_sel, full, req, elig, send;
  logic [VC_NUM-1:0][DATA_W-1:0] front;
  logic [VC_ID_W-1:0]            rr_ptr, sel_idx, idx;
  logic                          sel_vld;
  logic [STAGES:0]               vld_pipe;
  logic [DATA_W-1:0]             data_q;
  logic [VC_ID_W-1:0]            vc_q;

  // Async assert, release aligned to clk_i.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) rst_sync <= '0;
    else         rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];

  always_comb begin
    wr_sel = '0;
    if (bus.wr_en_i) wr_sel[bus.wr_vc_i] = 1'b1;
  end

  for (genvar v = 0; v < VC_NUM; v++) begin : g_lane
    vc_lane #(.VC_DEPTH_W(VC_DEPTH_W), .DATA_W(DATA_W)) u_lane (
      .gclk   (clk_i),
      .grst_n (rst_n),
      .push   (wr_sel[v]),
      .din    (bus.data_i),
      .grant  (bus.chan_alloc_i[v]),
      .send   (send[v]),
      .ds_rdy (bus.chan_rdy_i[v]),
      .full   (full[v]),
      .front  (front[v]),
      .req    (req[v]),
      .elig   (elig[v])
    );
  end

  // Round-robin: search starts one past the last VC that sent.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = rr_ptr;
    idx     = rr_ptr;
    for (int i = 1; i <= VC_NUM; i++) begin
      idx = VC_ID_W'((int'(rr_ptr) + i) % VC_NUM);
      if (!sel_vld && elig[idx]) begin
        sel_vld = 1'b1;
        sel_idx = idx;
      end
    end
    send = '0;
    if (sel_vld) send[sel_idx] = 1'b1;
  end

  assign vld_pipe[0] = sel_vld;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      data_q             <= '0;
      vc_q               <= '0;
      rr_ptr             <= VC_ID_W'(VC_NUM - 1);
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (sel_vld) begin
        data_q <= front[sel_idx];
        vc_q   <= sel_idx;
        rr_ptr <= sel_idx;
      end
    end
  end

  assign bus.rdy_o      = ~full;
  assign bus.req_o      = req;
  assign bus.header_o   = front;
  assign bus.data_o     = data_q;
  assign bus.data_vld_o = vld_pipe[STAGES];
  assign bus.data_vc_o  = vc_q;
endmodule
